// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory line arbiter.
//   ADDR_W_DEF / LINE_W_DEF : default address and line widths
//   state_e                 : arbiter FSM states
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // waiting for a requester
    BUSY    = 2'd1,  // request presented to memory, waiting for mem_ack_i
    RELEASE = 2'd2   // one-cycle ack pulse to the owner
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter. Signal names are written from the
// arbiter's point of view (the arbiter is the master).
//   mem_enable_o : memory request, high for the whole transaction
//   mem_write_o  : 1 = write, 0 = read
//   mem_addr_o   : line address
//   mem_data_o   : line write data
//   mem_data_i   : line read data
//   mem_ack_i    : one-cycle completion pulse from memory
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
);

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport master (
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin selector (purely combinational).
//   req0_i, req1_i : request lines of port 0 / port 1
//   last_i         : index of the port granted most recently
//   grant_o        : index of the selected port (meaningful when valid_o)
//   valid_o        : at least one port is requesting
module mem_arb_rr (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic grant_o,
  output logic valid_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid_o = req0_i | req1_i;
    grant_o = 1'b0;
    if (req0_i && req1_i) begin
      // On a tie, the port that was not served last wins.
      grant_o = ~last_i;
    end else if (req1_i) begin
      grant_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates line requests from icache (port 0) and dcache (port 1) onto a
// single memory bus. One transaction at a time: IDLE grants, BUSY waits for
// mem_ack_i, RELEASE pulses the owner's ack for one cycle.
//   clk_i, rst_i        : clock, synchronous active-low reset
//   pN_enable_i         : line request from port N
//   pN_write_i          : 1 = write, 0 = read
//   pN_addr_i/pN_data_i : line address / write data
//   pN_data_o           : last line read for port N
//   pN_ack_o            : one-cycle completion pulse
//   timeout_o           : sticky, set once a BUSY phase lasts TIMEOUT cycles
//   mem                 : memory bus (master side)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic [LINE_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              timeout_o,
  mem_arbiter_if.master     mem
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic              owner_q;
  logic              last_q;
  logic              enable_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata0_q;
  logic [LINE_W-1:0] rdata1_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              timeout_q;

  logic              grant;
  logic              grant_valid;

  mem_arb_rr u_rr (
    .req0_i  (p0_enable_i),
    .req1_i  (p1_enable_i),
    .last_i  (last_q),
    .grant_o (grant),
    .valid_o (grant_valid)
  );

  // BUSY-cycle counter saturates at TIMEOUT so it never wraps during a hang.
  assign count_d = (count_q == CNT_W'(TIMEOUT)) ? count_q : count_q + CNT_W'(1);

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;  // port 0 wins the first tie
      enable_q  <= 1'b0;
      write_q   <= 1'b0;
      // NOTE: the wide line registers are reset too because their reset value is visible on the ports.
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            // Snapshot the winner; the memory bus is driven only from these copies.
            owner_q  <= grant;
            last_q   <= grant;
            write_q  <= grant ? p1_write_i : p0_write_i;
            addr_q   <= grant ? p1_addr_i  : p0_addr_i;
            wdata_q  <= grant ? p1_data_i  : p0_data_i;
            enable_q <= 1'b1;
            count_q  <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          count_q <= count_d;
          if (count_d == CNT_W'(TIMEOUT)) begin
            timeout_q <= 1'b1;
          end
          if (mem.mem_ack_i) begin
            enable_q <= 1'b0;
            write_q  <= 1'b0;
            if (owner_q) begin
              rdata1_q <= mem.mem_data_i;
              ack1_q   <= 1'b1;
            end else begin
              rdata0_q <= mem.mem_data_i;
              ack0_q   <= 1'b1;
            end
            state_q <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_enable_o = enable_q;
  assign mem.mem_write_o  = write_q;
  assign mem.mem_addr_o   = addr_q;
  assign mem.mem_data_o   = wdata_q;
  assign p0_data_o        = rdata0_q;
  assign p1_data_o        = rdata1_q;
  assign p0_ack_o         = ack0_q;
  assign p1_ack_o         = ack1_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// compared against every output on every falling edge.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;

  logic          clk_i;
  logic          rst_i;
  logic          p0_enable_i, p0_write_i, p0_ack_o;
  logic [AW-1:0] p0_addr_i;
  logic [LW-1:0] p0_data_i, p0_data_o;
  logic          p1_enable_i, p1_write_i, p1_ack_o;
  logic [AW-1:0] p1_addr_i;
  logic [LW-1:0] p1_data_i, p1_data_o;
  logic          timeout_o;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) mem_bus ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .p0_enable_i (p0_enable_i),
    .p0_write_i  (p0_write_i),
    .p0_addr_i   (p0_addr_i),
    .p0_data_i   (p0_data_i),
    .p0_data_o   (p0_data_o),
    .p0_ack_o    (p0_ack_o),
    .p1_enable_i (p1_enable_i),
    .p1_write_i  (p1_write_i),
    .p1_addr_i   (p1_addr_i),
    .p1_data_i   (p1_data_i),
    .p1_data_o   (p1_data_o),
    .p1_ack_o    (p1_ack_o),
    .timeout_o   (timeout_o),
    .mem         (mem_bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic fail_bound(input string name, input int budget);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t: no ack within %0d cycles", name, $time, budget);
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_valid = 0;
  int            m_phase;       // 0 no transaction, 1 waiting on memory, 2 ack being delivered
  bit            m_last;
  bit            m_owner;
  int            m_busy;
  bit            m_timeout;
  logic          e_men, e_mwr, e_ack0, e_ack1;
  logic [AW-1:0] e_maddr;
  logic [LW-1:0] e_mdata, e_rd0, e_rd1;

  initial forever begin
    @(posedge clk_i);
    if (rst_i === 1'b0) begin
      m_valid = 1; m_phase = 0; m_last = 1; m_owner = 0; m_busy = 0; m_timeout = 0;
      e_men = 0; e_mwr = 0; e_ack0 = 0; e_ack1 = 0;
      e_maddr = '0; e_mdata = '0; e_rd0 = '0; e_rd1 = '0;
    end else if (m_valid) begin
      e_ack0 = 0;
      e_ack1 = 0;
      if (m_phase == 0) begin
        if (p0_enable_i || p1_enable_i) begin
          // tie -> the port not served last; otherwise the only requester
          m_owner = (p0_enable_i && p1_enable_i) ? !m_last : p1_enable_i;
          m_last  = m_owner;
          e_men   = 1;
          e_mwr   = m_owner ? p1_write_i : p0_write_i;
          e_maddr = m_owner ? p1_addr_i  : p0_addr_i;
          e_mdata = m_owner ? p1_data_i  : p0_data_i;
          m_busy  = 0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_busy++;
        if (m_busy >= TO) m_timeout = 1;
        if (mem_bus.mem_ack_i) begin
          e_men = 0;
          e_mwr = 0;
          if (m_owner) begin e_rd1 = mem_bus.mem_data_i; e_ack1 = 1; end
          else         begin e_rd0 = mem_bus.mem_data_i; e_ack0 = 1; end
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial forever begin
    @(negedge clk_i);
    if (m_valid) begin
      check("cmp_mem_enable", LW'(mem_bus.mem_enable_o), LW'(e_men));
      check("cmp_mem_write",  LW'(mem_bus.mem_write_o),  LW'(e_mwr));
      check("cmp_mem_addr",   LW'(mem_bus.mem_addr_o),   LW'(e_maddr));
      check("cmp_mem_data",   mem_bus.mem_data_o,        e_mdata);
      check("cmp_p0_ack",     LW'(p0_ack_o),             LW'(e_ack0));
      check("cmp_p1_ack",     LW'(p1_ack_o),             LW'(e_ack1));
      check("cmp_p0_data",    p0_data_o,                 e_rd0);
      check("cmp_p1_data",    p1_data_o,                 e_rd1);
      check("cmp_timeout",    LW'(timeout_o),            LW'(m_timeout));
    end
  end

  // ---------------- stimulus helpers ----------------
  int            mem_delay = 0;  // 0 = memory never answers by itself
  int            busy_seen = 0;
  logic [LW-1:0] resp_data = '0;
  int            ack_order[$];

  // One cycle: requesters drop after their ack, memory answers after mem_delay BUSY cycles.
  task automatic step();
    @(negedge clk_i);
    if (p0_ack_o) begin p0_enable_i = 0; ack_order.push_back(0); end
    if (p1_ack_o) begin p1_enable_i = 0; ack_order.push_back(1); end
    if (mem_bus.mem_ack_i) begin
      mem_bus.mem_ack_i = 0;
      busy_seen = 0;
    end else if (mem_bus.mem_enable_o && mem_delay > 0) begin
      busy_seen++;
      if (busy_seen >= mem_delay) begin
        mem_bus.mem_ack_i  = 1;
        mem_bus.mem_data_i = resp_data;
      end
    end else if (!mem_bus.mem_enable_o) begin
      busy_seen = 0;
    end
  endtask

  task automatic wait_ack(input int port, input int budget, output int cycles);
    bit seen = 0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      step();
      cycles++;
      seen = (port == 0) ? p0_ack_o : p1_ack_o;
    end
    if (!seen) fail_bound($sformatf("wait_ack_p%0d", port), budget);
  endtask

  task automatic wait_any_ack(input int budget, output int port);
    int cycles = 0;
    port = -1;
    while (port < 0 && cycles < budget) begin
      step();
      cycles++;
      if (p0_ack_o) port = 0;
      else if (p1_ack_o) port = 1;
    end
    if (port < 0) fail_bound("wait_any_ack", budget);
  endtask

  task automatic apply_reset();
    rst_i = 0;
    p0_enable_i = 0;
    p1_enable_i = 0;
    mem_bus.mem_ack_i = 0;
    mem_delay = 0;
    repeat (2) step();
    rst_i = 1;
    ack_order.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int lat;
    int port;
    int got[4];
    int exp_order[4] = '{0, 1, 0, 1};
    logic [LW-1:0] line_a5 = {8{32'hA5A5_A5A5}};
    logic [LW-1:0] wr_d    = {8{32'h1234_5678}};

    rst_i = 0;
    p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
    p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
    mem_bus.mem_ack_i = 0;
    mem_bus.mem_data_i = '0;

    // Reset state
    apply_reset();
    check("rst_mem_enable", LW'(mem_bus.mem_enable_o), LW'(0));
    check("rst_timeout",    LW'(timeout_o),            LW'(0));
    check("rst_p0_data",    p0_data_o,                 LW'(0));

    // Single read, memory answers after 10 BUSY cycles
    p0_write_i = 0; p0_addr_i = 32'h100; p0_enable_i = 1;
    mem_delay = 10; resp_data = line_a5;
    wait_ack(0, 40, lat);
    check("read_latency",   LW'(lat),          LW'(11));
    check("read_p0_data",   p0_data_o,         line_a5);
    check("read_ack_count", LW'(ack_order.size()), LW'(1));
    check("read_ack_port",  LW'(ack_order[0]), LW'(0));
    repeat (2) step();
    check("read_timeout_after_10", LW'(timeout_o), LW'(1));

    // mem_ack_i while IDLE is ignored
    mem_bus.mem_ack_i = 1;
    mem_bus.mem_data_i = {8{32'h5A5A_0F0F}};
    repeat (2) step();
    check("idle_ack_p0_data", p0_data_o, line_a5);
    check("idle_ack_no_ack",  LW'(ack_order.size()), LW'(1));

    // Minimum latency
    apply_reset();
    p1_write_i = 0; p1_addr_i = 32'h40; p1_enable_i = 1;
    mem_delay = 1; resp_data = {8{32'hC3C3_0001}};
    wait_ack(1, 20, lat);
    check("min_latency_cycles", LW'(lat + 1), LW'(3));
    check("min_latency_p1_data", p1_data_o, {8{32'hC3C3_0001}});
    repeat (2) step();

    // Simultaneous requests from reset: p0 first, then alternation
    apply_reset();
    p0_addr_i = 32'h1000; p1_addr_i = 32'h2000;
    p0_enable_i = 1; p1_enable_i = 1;
    mem_delay = 2; resp_data = {8{32'h0BAD_F00D}};
    for (int i = 0; i < 4; i++) begin
      wait_any_ack(30, port);
      got[i] = port;
      step();
      if (i < 2) begin
        if (port == 0) p0_enable_i = 1;
        else if (port == 1) p1_enable_i = 1;
      end
    end
    for (int i = 0; i < 4; i++) check($sformatf("tie_order_%0d", i), LW'(got[i]), LW'(exp_order[i]));
    repeat (2) step();

    // Back-to-back: p0 re-requests right after its ack while p1 waits
    apply_reset();
    p0_addr_i = 32'h300; p1_addr_i = 32'h400;
    p0_enable_i = 1; mem_delay = 3; resp_data = {8{32'h7777_0000}};
    step();
    p1_enable_i = 1;
    wait_ack(0, 20, lat);
    step();
    p0_enable_i = 1;
    wait_any_ack(20, port);
    check("b2b_second_grant", LW'(port), LW'(1));
    wait_any_ack(20, port);
    check("b2b_third_grant", LW'(port), LW'(0));
    repeat (2) step();

    // Write: latched address/data hold while the requester's inputs change
    p1_write_i = 1; p1_addr_i = 32'h200; p1_data_i = wr_d; p1_enable_i = 1;
    mem_delay = 5; resp_data = {8{32'h0000_1111}};
    for (int i = 0; i < 20; i++) begin
      step();
      if (p1_ack_o) break;
      if (mem_bus.mem_enable_o) begin
        check("wr_mem_write", LW'(mem_bus.mem_write_o), LW'(1));
        check("wr_mem_addr",  LW'(mem_bus.mem_addr_o),  LW'(32'h200));
        check("wr_mem_data",  mem_bus.mem_data_o,       wr_d);
        p1_data_i = {8{$urandom()}};
        p1_addr_i = $urandom();
      end
    end
    check("wr_acked", LW'(ack_order[ack_order.size() - 1]), LW'(1));
    p1_write_i = 0;
    repeat (2) step();

    // Timeout: no memory answer, flag sets after 8 BUSY cycles and sticks
    apply_reset();
    p0_write_i = 0; p0_addr_i = 32'h500; p0_enable_i = 1;
    for (int j = 1; j <= 15; j++) begin
      step();
      check($sformatf("to_cycle_%0d", j), LW'(timeout_o), LW'(j >= 9));
    end
    mem_bus.mem_ack_i = 1;
    mem_bus.mem_data_i = {8{32'hFACE_0042}};
    wait_ack(0, 5, lat);
    check("to_late_ack_data", p0_data_o, {8{32'hFACE_0042}});
    repeat (2) step();
    check("to_sticky", LW'(timeout_o), LW'(1));

    // Reset in the middle of BUSY abandons the transaction
    apply_reset();
    p1_write_i = 0; p1_addr_i = 32'h600; p1_enable_i = 1;
    repeat (3) step();
    rst_i = 0;
    p1_enable_i = 0;
    mem_bus.mem_ack_i = 1;
    mem_bus.mem_data_i = {8{32'hDEAD_BEEF}};
    step();
    check("rst_busy_enable", LW'(mem_bus.mem_enable_o), LW'(0));
    rst_i = 1;
    repeat (3) step();
    check("rst_busy_no_ack", LW'(ack_order.size()), LW'(0));
    p0_addr_i = 32'h700; p0_enable_i = 1;
    mem_delay = 2; resp_data = {8{32'h2468_ACE0}};
    wait_ack(0, 20, lat);
    check("rst_fresh_data", p0_data_o, {8{32'h2468_ACE0}});
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
- REQ-002 SHALL have parameter LINE_W, default 256, memory line data width.
- REQ-003 SHALL have parameter TIMEOUT, default 64, cycles in BUSY before timeout_o sets.
- REQ-004 SHALL have clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
- REQ-005 SHALL have rst_i, input, 1 bit, synchronous active-low reset.
- REQ-006 SHALL have pN_enable_i (N=0 icache, N=1 dcache), input, 1 bit each, line request.
- REQ-007 SHALL have pN_write_i, input, 1 bit each: 1 = write, 0 = read.
- REQ-008 SHALL have pN_addr_i, input, ADDR_W each, line address.
- REQ-009 SHALL have pN_data_i, input, LINE_W each, write data.
- REQ-010 SHALL have pN_data_o, output, LINE_W each, read data.
- REQ-011 SHALL have pN_ack_o, output, 1 bit each, transaction-complete pulse.
- REQ-012 SHALL have mem_data_i, input, LINE_W, memory read data.
- REQ-013 SHALL have mem_ack_i, input, 1 bit, memory completion pulse.
- REQ-014 SHALL have mem_data_o, output, LINE_W, memory write data.
- REQ-015 SHALL have mem_addr_o, output, ADDR_W, memory address.
- REQ-016 SHALL have mem_enable_o, output, 1 bit, memory request.
- REQ-017 SHALL have mem_write_o, output, 1 bit, memory write strobe.
- REQ-018 SHALL have timeout_o, output, 1 bit, sticky watchdog flag.

Function
- REQ-019 SHALL implement FSM states IDLE, BUSY, RELEASE.
- REQ-020 In IDLE with any pN_enable_i=1, SHALL select one owner and latch its write, addr and data into registers, then enter BUSY on the next edge.
- REQ-021 Selection SHALL be round-robin: if both ports request, grant the port not granted last; if one requests, grant it.
- REQ-022 In BUSY, mem_enable_o SHALL be 1 and mem_addr_o, mem_write_o and mem_data_o SHALL come from the latched registers only; later requester changes SHALL have no effect.
- REQ-023 In BUSY with mem_ack_i=1, SHALL capture mem_data_i into the owner's read-data register and enter RELEASE.
- REQ-024 In RELEASE, mem_enable_o SHALL be 0 and the owner's pN_ack_o SHALL be 1 for exactly that cycle; the state SHALL then return to IDLE.
- REQ-025 The non-owner's ack SHALL stay 0, and its data_o SHALL hold its last value.
- REQ-026 A requester SHALL drop pN_enable_i in the cycle after pN_ack_o, so IDLE never re-grants a completed request.
- REQ-027 Minimum latency from request to ack SHALL be 3 cycles: grant edge, one BUSY cycle with mem_ack_i, then RELEASE.
- REQ-028 mem_ack_i outside BUSY SHALL be ignored.
- REQ-029 A request arriving while BUSY or RELEASE SHALL wait, with no loss, until IDLE.
- REQ-030 A BUSY-cycle counter SHALL clear on entry to BUSY and saturate; when it reaches TIMEOUT, timeout_o SHALL set and stay set until reset, while the FSM keeps waiting.
- REQ-031 The last-grant register SHALL update only at a grant.

Reset
- REQ-032 With rst_i=0 at a clock edge: state=IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, pN_ack_o=0, pN_data_o=0, timeout_o=0, counter=0, and last-grant=1 so port 0 wins the first tie.
- REQ-033 Reset during BUSY SHALL abandon the transaction without any ack, and mem_enable_o SHALL be 0 from the first cycle after that edge.

Structure
- REQ-034 Package mem_arb_pkg SHALL hold the state enum and the ADDR_W/LINE_W defaults.
- REQ-035 Round-robin selection SHALL live in one sub-module, mem_arb_rr (inputs: two requests and last-grant; outputs: grant index and valid).

Verification
- REQ-036 Single read: p0 read at 0x100, memory acks after 10 cycles with 0xA5..A5 -> p0_ack_o pulses once, p0_data_o=0xA5..A5, p1_ack_o stays 0.
- REQ-037 Simultaneous: both ports request from reset -> p0 served first, then p1; the grant order after that alternates.
- REQ-038 Write: p1 write at 0x200 with data D -> mem_write_o=1, mem_addr_o=0x200, mem_data_o=D held stable through BUSY, even while p1_data_i changes.
- REQ-039 Back-to-back: p0 requests again right after its ack while p1 is waiting -> p1 is granted next.
- REQ-040 Timeout: TIMEOUT=8 and no mem_ack_i -> timeout_o=1 after 8 BUSY cycles and stays 1; a later ack still completes the transaction.
- REQ-041 Reset mid-BUSY -> no ack on either port, mem_enable_o=0 the next cycle, and a fresh request afterwards completes normally.
